crc16_frame_checker: RTL and testbench
======================================

// Module: crc16_frame_checker
// PURPOSE
//  Receive-side counterpart of the CRC-16 parallel generator. Accepts 16-bit words over
//  valid/ready; each frame is N payload words plus a trailing CRC word flagged by s_last.
//  Recomputes the CRC over the payload and compares it with the received CRC word.
//  Forwards payload downstream (CRC word stripped), then reports per-frame status.
// PARAMETERS
//  POLY      16'h8005  CRC polynomial x^16+x^15+x^2+1 (implicit x^16)
//  INIT      16'h0000  CRC register value at start of every frame
//  MAX_WORDS 256       max payload words per frame; more than this = length error
//  CNT_W     8         width of saturating error counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  s_valid    in   1      input word valid
//  s_ready    out  1      input ready; a word transfers when s_valid&&s_ready
//  s_data     in   16     payload word or, with s_last, received CRC
//  s_last     in   1      marks CRC word (final word of frame)
//  m_valid    out  1      output payload word valid
//  m_ready    in   1      downstream ready
//  m_data     out  16     forwarded payload word
//  m_last     out  1      last payload word of frame
//  m_err      out  1      qualifies m_last: frame truncated on overflow
//  frame_done out  1      1-cycle pulse after the CRC word of a frame is accepted
//  crc_ok     out  1      valid with frame_done: CRC matched, length legal
//  crc_err    out  1      valid with frame_done: CRC mismatch, length legal
//  len_err    out  1      valid with frame_done: runt (0 payload words) or overflow
//  err_count  out  CNT_W  frames with crc_err|len_err; saturates at all-ones
// BEHAVIOUR
//  - Reset (reset_n=0, async): all outputs 0, FSM=IDLE, crc=INIT, hold empty, count 0.
//  - CRC step per word, MSB first, 16 iterations: fb=crc[15]^d[i];
//    crc={crc[14:0],1'b0}^(fb?POLY:0). No reflection, no final XOR. Combinational, one word/cycle.
//  - s_ready = !m_valid || m_ready (output register free or draining this cycle).
//  - One-word hold register H delays payload so the last payload word is known when s_last arrives.
//  - On a non-last accepted word w: crc<=step(crc,w); len++; if H full, m_data<=H, m_valid<=1,
//    m_last<=0; H<=w.
//  - On an accepted s_last word w with H full: m_data<=H, m_valid<=1, m_last<=1;
//    compare crc with w; H emptied; crc<=INIT; len<=0.
//  - m_valid held with stable m_data/m_last/m_err until m_ready; cleared on m_ready with no new load.
//  - FSM: IDLE (no word of current frame yet) -> RX on first non-last word.
//    IDLE + s_last = runt: len_err, no output, stays IDLE.
//    RX + s_last -> IDLE, status as above.
//    RX + non-last word making len>MAX_WORDS -> DROP: emit H with m_last=1,m_err=1; word discarded.
//    DROP: accept and discard all words (s_ready still obeys output rule); s_last -> IDLE with len_err.
//  - Status registered: frame_done/crc_ok|crc_err|len_err pulse 1 cycle after the s_last
//    transfer, exactly one of the three set; all three 0 when frame_done=0.
//  - err_count increments with frame_done&&(crc_err||len_err); holds at 2^CNT_W-1.
//  - Back-to-back frames: word after s_last starts new frame with crc=INIT, zero bubbles.
//  - s_valid low mid-frame: state held, no timeout.
//  - Reset mid-frame or while m_valid: frame and pending output discarded, no status pulse.
// STRUCTURE
//  - Package crc16_pkg: CRC16_POLY, CRC16_INIT, state enum {IDLE,RX,DROP}, function crc16_step
//    (word-wide step) shared with the generator.
//  - One natural sub-module: crc16_word_step (pure combinational 16-bit CRC update);
//    FSM, hold register, output register and counters in top.
// TESTING
//  - Frame {0x0001, CRC 0x8005} -> m_data 0x0001 m_last=1; frame_done, crc_ok=1, err_count=0.
//  - Frame {0x0001, CRC 0x8004} -> payload forwarded; crc_err=1; err_count=1.
//  - Frame {0x0000,0x0000,0x0000, CRC 0x0000} with m_ready low 5 cycles mid-frame -> no
//    data loss or duplication, 3 words out in order, crc_ok.
//  - Lone s_last word 0x1234 in IDLE -> no m_valid; len_err=1; err_count+1.
//  - MAX_WORDS=4, 6 payload words + CRC -> 4 words out, 4th m_last=1 m_err=1; len_err on CRC word.
//  - err_count forced past 255 -> stays 255; reset_n low mid-frame -> all outputs 0, next frame crc_ok.

Source files
------------

// File: rtl/crc16_frame_checker_pkg.sv
// Shared CRC-16 definitions: polynomial, init value, checker FSM states and
// the word-wide CRC update used by both the generator and the checker.
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        DROP = 2'd2
    } state_e;

    // MSB-first, non-reflected, no final XOR.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [15:0] d,
                                               input logic [15:0] poly);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_frame_checker_if.sv
// 16-bit valid/ready word stream with a last flag and a truncation flag.
interface crc16_frame_checker_if;
    logic        valid;
    logic        ready;
    logic [15:0] data;
    logic        last;
    logic        err;

    modport master (output valid, data, last, err, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/crc16_frame_checker_word_step.sv
// Combinational one-word CRC-16 update.
module crc16_word_step
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY
) (
    input  logic [15:0] crc_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o
);

    assign crc_o = crc16_step(crc_i, data_i, POLY);

endmodule

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 frame checker: strips and verifies the trailing CRC word,
// forwards payload through a one-word hold stage and reports per-frame status.
module crc16_frame_checker
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY      = CRC16_POLY,
    parameter logic [15:0] INIT      = CRC16_INIT,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    crc16_frame_checker_if.slave  s,
    crc16_frame_checker_if.master m,
    output logic                 frame_done,
    output logic                 crc_ok,
    output logic                 crc_err,
    output logic                 len_err,
    output logic [CNT_W-1:0]     err_count
);

    localparam int               LEN_W   = $clog2(MAX_WORDS + 2);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    state_e             state_q;
    logic [15:0]        crc_q;
    logic [15:0]        crc_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic [15:0]        h_q;
    logic               m_valid_q;
    logic [15:0]        m_data_q;
    logic               m_last_q;
    logic               m_err_q;
    logic               done_q;
    logic               ok_q;
    logic               cerr_q;
    logic               lerr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               acc;

    crc16_word_step #(.POLY(POLY)) u_step (
        .crc_i  (crc_q),
        .data_i (s.data),
        .crc_o  (crc_d)
    );

    assign s.ready = !m_valid_q || m.ready;
    assign acc     = s.valid && s.ready;
    assign len_d   = len_q + 1'b1;
    assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    assign m.valid    = m_valid_q;
    assign m.data     = m_data_q;
    assign m.last     = m_last_q;
    assign m.err      = m_err_q;
    assign frame_done = done_q;
    assign crc_ok     = ok_q;
    assign crc_err    = cerr_q;
    assign len_err    = lerr_q;
    assign err_count  = cnt_q;

    // The hold register is full exactly while in RX, so no separate flag is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            len_q     <= '0;
            h_q       <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_err_q   <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            cerr_q    <= 1'b0;
            lerr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            cerr_q <= 1'b0;
            lerr_q <= 1'b0;
            if (m.ready) m_valid_q <= 1'b0;
            if (acc) begin
                case (state_q)
                    IDLE: begin
                        if (s.last) begin
                            done_q <= 1'b1;
                            lerr_q <= 1'b1;
                            cnt_q  <= cnt_d;
                        end else begin
                            crc_q   <= crc_d;
                            len_q   <= LEN_W'(1);
                            h_q     <= s.data;
                            state_q <= RX;
                        end
                    end
                    RX: begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= h_q;
                        if (s.last) begin
                            m_last_q <= 1'b1;
                            m_err_q  <= 1'b0;
                            done_q   <= 1'b1;
                            ok_q     <= (crc_q == s.data);
                            cerr_q   <= (crc_q != s.data);
                            if (crc_q != s.data) cnt_q <= cnt_d;
                            crc_q    <= INIT;
                            len_q    <= '0;
                            state_q  <= IDLE;
                        end else if (len_d > MAX_LEN) begin
                            // Overflowing word is discarded; held word closes the truncated frame.
                            m_last_q <= 1'b1;
                            m_err_q  <= 1'b1;
                            state_q  <= DROP;
                        end else begin
                            m_last_q <= 1'b0;
                            m_err_q  <= 1'b0;
                            crc_q    <= crc_d;
                            len_q    <= len_d;
                            h_q      <= s.data;
                        end
                    end
                    DROP: begin
                        if (s.last) begin
                            done_q  <= 1'b1;
                            lerr_q  <= 1'b1;
                            cnt_q   <= cnt_d;
                            crc_q   <= INIT;
                            len_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Scoreboard bench for crc16_frame_checker: directed frames on a full-size and a
// MAX_WORDS=4 instance, with monitors popping expected beats and status.
module tb_crc16_frame_checker;
    import crc16_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        err;
    } beat_t;

    typedef struct packed {
        logic ok;
        logic cerr;
        logic lerr;
    } stat_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       fd1, ok1, ce1, le1, fd2, ok2, ce2, le2;
    logic [7:0] cnt1, cnt2;

    always #5 clk = ~clk;

    crc16_frame_checker_if s1();
    crc16_frame_checker_if m1();
    crc16_frame_checker_if s2();
    crc16_frame_checker_if m2();

    crc16_frame_checker #(.MAX_WORDS(256), .CNT_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .s(s1), .m(m1),
        .frame_done(fd1), .crc_ok(ok1), .crc_err(ce1), .len_err(le1), .err_count(cnt1)
    );

    crc16_frame_checker #(.MAX_WORDS(4), .CNT_W(8)) dut2 (
        .clk(clk), .reset_n(reset_n), .s(s2), .m(m2),
        .frame_done(fd2), .crc_ok(ok2), .crc_err(ce2), .len_err(le2), .err_count(cnt2)
    );

    beat_t       dq1[$], dq2[$];
    stat_t       sq1[$], sq2[$];
    logic [15:0] pay[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_cnt1 = 0;
    int          exp_cnt2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin
        beat_t b;
        stat_t st;
        if (reset_n) begin
            if (m1.valid && m1.ready) begin
                if (dq1.size() == 0) fail("dut1 unexpected output beat");
                else begin b = dq1.pop_front(); check("dut1 beat {data,last,err}", {m1.data, m1.last, m1.err}, b); end
            end
            if (fd1) begin
                if (sq1.size() == 0) fail("dut1 unexpected frame_done");
                else begin st = sq1.pop_front(); check("dut1 status {ok,cerr,lerr}", {ok1, ce1, le1}, st); end
            end
            if (m2.valid && m2.ready) begin
                if (dq2.size() == 0) fail("dut2 unexpected output beat");
                else begin b = dq2.pop_front(); check("dut2 beat {data,last,err}", {m2.data, m2.last, m2.err}, b); end
            end
            if (fd2) begin
                if (sq2.size() == 0) fail("dut2 unexpected frame_done");
                else begin st = sq2.pop_front(); check("dut2 status {ok,cerr,lerr}", {ok2, ce2, le2}, st); end
            end
        end
    end

    task automatic send(input bit which, input logic [15:0] w, input logic last);
        int   t;
        logic rdy;
        if (which) begin s2.valid = 1'b1; s2.data = w; s2.last = last; end
        else       begin s1.valid = 1'b1; s1.data = w; s1.last = last; end
        t = 0;
        do begin
            @(negedge clk);
            rdy = which ? s2.ready : s1.ready;
            @(posedge clk); #1;
            t++;
        end while (!rdy && t < 200);
        if (!rdy) fail("send timeout waiting for s_ready");
        s1.valid = 1'b0;
        s2.valid = 1'b0;
    endtask

    // Frame from global pay plus trailing crc; nout beats expected, last one truncated if trunc.
    task automatic run_frame(input bit which, input logic [15:0] crc, input stat_t st,
                             input int nout, input logic trunc);
        for (int i = 0; i < nout; i++) begin
            if (which) dq2.push_back(beat_t'{data: pay[i], last: (i == nout - 1), err: trunc && (i == nout - 1)});
            else       dq1.push_back(beat_t'{data: pay[i], last: (i == nout - 1), err: trunc && (i == nout - 1)});
        end
        if (which) begin
            sq2.push_back(st);
            if ((st.cerr || st.lerr) && exp_cnt2 < 255) exp_cnt2++;
        end else begin
            sq1.push_back(st);
            if ((st.cerr || st.lerr) && exp_cnt1 < 255) exp_cnt1++;
        end
        foreach (pay[i]) send(which, pay[i], 1'b0);
        send(which, crc, 1'b1);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    localparam stat_t ST_OK   = '{ok: 1'b1, cerr: 1'b0, lerr: 1'b0};
    localparam stat_t ST_CERR = '{ok: 1'b0, cerr: 1'b1, lerr: 1'b0};
    localparam stat_t ST_LERR = '{ok: 1'b0, cerr: 1'b0, lerr: 1'b1};

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        s1.valid = 1'b0; s1.data = '0; s1.last = 1'b0; s1.err = 1'b0;
        s2.valid = 1'b0; s2.data = '0; s2.last = 1'b0; s2.err = 1'b0;
        m1.ready = 1'b1; m2.ready = 1'b1;
        #1;
        check("reset outputs dut1", {m1.valid, m1.data, m1.last, m1.err, fd1, ok1, ce1, le1, cnt1}, 0);
        check("reset outputs dut2", {m2.valid, m2.data, m2.last, m2.err, fd2, ok2, ce2, le2, cnt2}, 0);
        check("reset s_ready", {s1.ready, s2.ready}, 2'b11);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        pay = '{16'h0001};
        run_frame(0, 16'h8005, ST_OK, 1, 1'b0);
        settle();
        check("err_count after good frame", cnt1, exp_cnt1);

        pay = '{16'h0001};
        run_frame(0, 16'h8004, ST_CERR, 1, 1'b0);
        settle();
        check("err_count after crc_err", cnt1, exp_cnt1);

        pay = '{16'h0000, 16'h0000, 16'h0000};
        fork
            run_frame(0, 16'h0000, ST_OK, 3, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #2 m1.ready = 1'b0;
                repeat (5) @(posedge clk);
                #2 m1.ready = 1'b1;
            end
        join
        settle();

        pay = {};
        run_frame(0, 16'h1234, ST_LERR, 0, 1'b0);
        settle();
        check("err_count after runt", cnt1, exp_cnt1);

        // Back-to-back frames with no idle cycle between them.
        pay = '{16'h0002};
        run_frame(0, 16'h800F, ST_OK, 1, 1'b0);
        pay = '{16'h0000, 16'h0001};
        run_frame(0, 16'h8005, ST_OK, 2, 1'b0);
        settle();

        pay = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
        run_frame(1, 16'hABCD, ST_LERR, 4, 1'b1);
        pay = '{16'h0000, 16'h0000, 16'h0000, 16'h0001};
        run_frame(1, 16'h8005, ST_OK, 4, 1'b0);
        pay = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        run_frame(1, 16'h0000, ST_LERR, 4, 1'b1);
        settle();
        check("dut2 err_count after overflows", cnt2, exp_cnt2);

        pay = {};
        repeat (260) run_frame(0, 16'h1234, ST_LERR, 0, 1'b0);
        settle();
        check("err_count saturates", cnt1, 255);
        check("err_count model saturates", exp_cnt1, 255);

        m1.ready = 1'b0;
        send(0, 16'h0011, 1'b0);
        send(0, 16'h0022, 1'b0);
        @(negedge clk);
        check("m_valid pending before reset", m1.valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid-frame reset outputs", {m1.valid, m1.data, m1.last, m1.err, fd1, ok1, ce1, le1, cnt1}, 0);
        exp_cnt1 = 0;
        exp_cnt2 = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m1.ready = 1'b1;
        @(posedge clk); #1;
        pay = '{16'h0001};
        run_frame(0, 16'h8005, ST_OK, 1, 1'b0);
        settle();
        check("err_count after reset and good frame", cnt1, exp_cnt1);

        check("scoreboard queues drained", dq1.size() + dq2.size() + sq1.size() + sq2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
